// File: rtl/sprite_blit.sv
// sprite_blit: copies one sprite from a synchronous ROM into the framebuffer
// with X/Y integer scaling, H/V flip and signed placement clipped to screen.
// Ports: clk, rst (sync, active-low); start/busy/done handshake;
// sx/sy signed position, scale_x/scale_y (scale-1), flip_h/flip_v;
// spr_addr/spr_data ROM port (1-cycle read); fb_addr/fb_pix/fb_we/fb_ready
// framebuffer write port with backpressure.
// Option: define SPRITE_BLIT_HALF_FB_EN for a half-resolution packed fb_addr.
module sprite_blit #(
  parameter int CORDW      = 10,
  parameter int SPR_WIDTH  = 32,
  parameter int SPR_HEIGHT = 32,
  parameter int SPR_DATAW  = 4,
  parameter int SCALEW     = 3,
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 480,
  parameter int FB_ADDRW   = 19,
  parameter logic [SPR_DATAW-1:0] TRANSP = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [CORDW:0]   sx,
  input  logic signed [CORDW:0]   sy,
  input  logic [SCALEW-1:0]       scale_x,
  input  logic [SCALEW-1:0]       scale_y,
  input  logic                    flip_h,
  input  logic                    flip_v,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(SPR_WIDTH*SPR_HEIGHT)-1:0] spr_addr,
  input  logic [SPR_DATAW-1:0]    spr_data,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [SPR_DATAW-1:0]    fb_pix,
  output logic                    fb_we,
  input  logic                    fb_ready
);

  localparam int XB  = $clog2(SPR_WIDTH);
  localparam int YB  = $clog2(SPR_HEIGHT);
  localparam int WXW = XB + SCALEW;
  localparam int WYW = YB + SCALEW;
  localparam int CW  = CORDW + 2;
  localparam logic [CW-1:0] SW_C = CW'(SCREEN_W);
  localparam logic [CW-1:0] SH_C = CW'(SCREEN_H);
  localparam logic [FB_ADDRW-1:0] PITCH = FB_ADDRW'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, nstate;

  logic [CORDW:0]       sx_q, sy_q;
  logic [SCALEW-1:0]    scx, scy;
  logic                 fh, fv;
  logic [XB-1:0]        rx, cx;
  logic [YB-1:0]        ry, cy;
  logic [SCALEW-1:0]    subx, suby;
  logic [WXW-1:0]       wx;
  logic [WYW-1:0]       wy;
  logic                 flush_cnt;
  logic                 s1_v;
  logic [CW-1:0]        s1_x, s1_y;
  logic [CW-1:0]        x0, y0;
  logic                 stl_q;
  logic [SPR_DATAW-1:0] hold_pix, pix1;
  logic [FB_ADDRW-1:0]  lin, fa;
  logic                 stall, col_end, row_end, last;
  logic                 inx, iny;

  assign stall   = fb_we & ~fb_ready;
  assign col_end = (subx == scx) && (rx == XB'(SPR_WIDTH-1));
  assign row_end = (suby == scy) && (ry == YB'(SPR_HEIGHT-1));
  assign last    = col_end && row_end;

  // Power-of-two sprite: W-1-rx is the bitwise inverse
  assign cx       = fh ? ~rx : rx;
  assign cy       = fv ? ~ry : ry;
  assign spr_addr = {cy, cx};

  assign x0 = {sx_q[CORDW], sx_q} + CW'(wx);
  assign y0 = {sy_q[CORDW], sy_q} + CW'(wy);

  // The ROM keeps reading while stalled, so the stage-1 word is
  // parked on the first stall cycle and replayed until release.
  assign pix1 = stl_q ? hold_pix : spr_data;

  assign inx = !s1_x[CW-1] && (s1_x < SW_C);
  assign iny = !s1_y[CW-1] && (s1_y < SH_C);
  assign lin = FB_ADDRW'(s1_x) + FB_ADDRW'(s1_y) * PITCH;

`ifdef SPRITE_BLIT_HALF_FB_EN
  assign fa = lin >> 1;
`else
  assign fa = lin;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state)
      IDLE:  if (start) nstate = RUN;
      RUN: begin
        busy = 1'b1;
        if (!stall && last) nstate = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (!stall && flush_cnt) nstate = DONE;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sx_q <= '0; sy_q <= '0;
      scx <= '0; scy <= '0;
      fh <= 1'b0; fv <= 1'b0;
      rx <= '0; ry <= '0;
      subx <= '0; suby <= '0;
      wx <= '0; wy <= '0;
      flush_cnt <= 1'b0;
      s1_v <= 1'b0; s1_x <= '0; s1_y <= '0;
      stl_q <= 1'b0; hold_pix <= '0;
      fb_we <= 1'b0; fb_addr <= '0; fb_pix <= '0;
    end else begin
      if (state == IDLE && start) begin
        sx_q <= sx; sy_q <= sy;
        scx <= scale_x; scy <= scale_y;
        fh <= flip_h; fv <= flip_v;
        rx <= '0; ry <= '0;
        subx <= '0; suby <= '0;
        wx <= '0; wy <= '0;
        flush_cnt <= 1'b0;
      end
      if (!stall) begin
        if (state == RUN) begin
          wx <= col_end ? '0 : wx + WXW'(1);
          if (subx == scx) begin
            subx <= '0;
            rx   <= rx + XB'(1);
          end else begin
            subx <= subx + SCALEW'(1);
          end
          if (col_end) begin
            wy <= row_end ? '0 : wy + WYW'(1);
            if (suby == scy) begin
              suby <= '0;
              ry   <= ry + YB'(1);
            end else begin
              suby <= suby + SCALEW'(1);
            end
          end
        end
        if (state == FLUSH) flush_cnt <= 1'b1;
        s1_v    <= (state == RUN);
        s1_x    <= x0;
        s1_y    <= y0;
        fb_we   <= s1_v && (pix1 != TRANSP) && inx && iny;
        fb_addr <= fa;
        fb_pix  <= pix1;
      end
      stl_q <= stall;
      if (!stl_q) hold_pix <= spr_data;
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// tb_sprite_blit: directed bench for sprite_blit with a ROM model,
// a framebuffer write recorder and a reference write list per blit.
module tb_sprite_blit;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [10:0] sx = '0;
  logic signed [10:0] sy = '0;
  logic [2:0]         scale_x = '0;
  logic [2:0]         scale_y = '0;
  logic               flip_h = 1'b0;
  logic               flip_v = 1'b0;
  logic               busy, done;
  logic [9:0]         spr_addr;
  logic [3:0]         spr_data;
  logic [18:0]        fb_addr;
  logic [3:0]         fb_pix;
  logic               fb_we;
  logic               fb_ready = 1'b1;

  logic [3:0] rom [1024];
  int wa[$];
  int wd[$];
  int ea[$];
  int ed[$];
  int n_chk = 0;
  int n_pass = 0;

  sprite_blit dut (
    .clk(clk), .rst(rst), .start(start),
    .sx(sx), .sy(sy),
    .scale_x(scale_x), .scale_y(scale_y),
    .flip_h(flip_h), .flip_v(flip_v),
    .busy(busy), .done(done),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_addr(fb_addr), .fb_pix(fb_pix),
    .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) spr_data <= rom[spr_addr];

  always @(negedge clk)
    if (fb_we && fb_ready) begin
      wa.push_back(int'(fb_addr));
      wd.push_back(int'(fb_pix));
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int fa(input int x, input int y);
    int a;
    a = x + y * 800;
`ifdef SPRITE_BLIT_HALF_FB_EN
    a = a >> 1;
`endif
    return a;
  endfunction

  // Reference: divide-based source lookup over the full output scan
  task automatic model(input int x0, input int y0, input int kx,
                       input int ky, input int fh, input int fv);
    int c, r, p, x, y;
    ea.delete();
    ed.delete();
    for (int wy = 0; wy < 32 * (ky + 1); wy++)
      for (int wx = 0; wx < 32 * (kx + 1); wx++) begin
        c = wx / (kx + 1);
        r = wy / (ky + 1);
        if (fh != 0) c = 31 - c;
        if (fv != 0) r = 31 - r;
        p = int'(rom[c + r * 32]);
        x = x0 + wx;
        y = y0 + wy;
        if (p != 15 && x >= 0 && x < 800 && y >= 0 && y < 480) begin
          ea.push_back(fa(x, y));
          ed.push_back(p);
        end
      end
  endtask

  task automatic cmp_list(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < wa.size() && i < ea.size(); i++)
      if (wa[i] != ea[i] || wd[i] != ed[i]) errs++;
    chk({tag, "_nwr"}, wa.size(), ea.size());
    chk({tag, "_errs"}, errs, 0);
  endtask

  task automatic blit(input int x, input int y, input int kx,
                      input int ky, input int fh, input int fv,
                      input int stall_at, input int rst_at,
                      output int cyc, output int busy_bad,
                      output int hold_bad);
    int ha, hp;
    cyc = 0;
    busy_bad = 0;
    hold_bad = 0;
    @(posedge clk); #1;
    wa.delete();
    wd.delete();
    sx = 11'(x);
    sy = 11'(y);
    scale_x = 3'(kx);
    scale_y = 3'(ky);
    flip_h = fh[0];
    flip_v = fv[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sx = 11'sd5;
    sy = 11'sd7;
    scale_x = 3'd4;
    scale_y = 3'd4;
    flip_h = ~flip_h;
    flip_v = ~flip_v;
    while (1) begin
      if (done) begin
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (cyc >= 7000) break;
      if (stall_at >= 0 && wa.size() == stall_at && fb_we) begin
        ha = int'(fb_addr);
        hp = int'(fb_pix);
        fb_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          cyc++;
          if (int'(fb_addr) != ha || int'(fb_pix) != hp || !fb_we || !busy)
            hold_bad++;
        end
        fb_ready = 1'b1;
        stall_at = -1;
      end
      if (rst_at >= 0 && wa.size() == rst_at && fb_we) begin
        rst = 1'b0;
        @(posedge clk); #1;
        cyc++;
        rst = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, bb, hb, n0, dn, hit;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_pix", int'(fb_pix), 0);
    chk("rst_spr_addr", int'(spr_addr), 0);
    rst = 1'b1;

    // identity blit
    for (int i = 0; i < 1024; i++) rom[i] = 4'(((i % 32) + (i / 32)) % 15);
    blit(0, 0, 0, 0, 0, 0, -1, -1, cyc, bb, hb);
    chk("id_cycles", cyc, 1026);
    chk("id_busy", bb, 0);
    chk("id_w32_addr", wa.size() > 32 ? wa[32] : -1, fa(0, 1));
    chk("id_w33_data", wd.size() > 33 ? wd[33] : -1, 2);
    model(0, 0, 0, 0, 0, 0);
    cmp_list("id");
    @(posedge clk); #1;
    chk("id_done_pulse", int'(done), 0);

    // transparency plus scale 2x3
    for (int i = 0; i < 1024; i++) rom[i] = 4'hF;
    rom[0] = 4'd3;
    blit(0, 0, 1, 2, 0, 0, -1, -1, cyc, bb, hb);
    chk("ts_cycles", cyc, 6146);
    chk("ts_nwr", wa.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("ts_addr", k < wa.size() ? wa[k] : -1, fa(k % 2, k / 2));
      chk("ts_data", k < wd.size() ? wd[k] : -1, 3);
    end

    // horizontal flip at (10,10)
    for (int i = 0; i < 1024; i++) rom[i] = 4'(i % 32);
    blit(10, 10, 0, 0, 1, 0, -1, -1, cyc, bb, hb);
    chk("fl_cycles", cyc, 1026);
    chk("fl_nwr", wa.size(), 960);
    chk("fl_first_addr", wa.size() > 0 ? wa[0] : -1, fa(11, 10));
    chk("fl_first_data", wd.size() > 0 ? wd[0] : -1, 14);
    hit = 0;
    foreach (wa[i]) if (wa[i] == fa(10, 10)) hit++;
    chk("fl_transp_skip", hit, 0);
    model(10, 10, 0, 0, 1, 0);
    cmp_list("fl");

    // clipping at (-16,470)
    for (int i = 0; i < 1024; i++) rom[i] = 4'(((i % 32) + (i / 32)) % 15);
    blit(-16, 470, 0, 0, 0, 0, -1, -1, cyc, bb, hb);
    chk("cl_cycles", cyc, 1026);
    chk("cl_nwr", wa.size(), 160);
    chk("cl_first_addr", wa.size() > 0 ? wa[0] : -1, fa(0, 470));
    chk("cl_first_data", wd.size() > 0 ? wd[0] : -1, 1);
    model(-16, 470, 0, 0, 0, 0);
    cmp_list("cl");

    // backpressure on pixel 100
    blit(0, 0, 0, 0, 0, 0, 100, -1, cyc, bb, hb);
    chk("bp_cycles", cyc, 1031);
    chk("bp_hold", hb, 0);
    chk("bp_busy", bb, 0);
    model(0, 0, 0, 0, 0, 0);
    cmp_list("bp");

    // reset at pixel 500, then a clean blit
    blit(0, 0, 0, 0, 0, 0, -1, 500, cyc, bb, hb);
    chk("mr_busy", int'(busy), 0);
    chk("mr_fb_we", int'(fb_we), 0);
    chk("mr_done", int'(done), 0);
    n0 = wa.size();
    dn = 0;
    repeat (1100) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mr_no_done", dn, 0);
    chk("mr_no_writes", wa.size() - n0, 0);
    blit(0, 0, 0, 0, 0, 0, -1, -1, cyc, bb, hb);
    chk("mr2_cycles", cyc, 1026);
    chk("mr2_busy", bb, 0);
    cmp_list("mr2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_blit.md
Name: sprite_blit

Overview:
- Second-generation sprite renderer that copies one sprite from sprite ROM into the framebuffer.
- New over the first generation: independent X/Y integer scaling, horizontal/vertical flip, and signed placement with screen-edge clipping.
- Also new: a start/busy/done handshake, a registered synchronous-ROM read pipeline, and framebuffer backpressure.
- Sits between the sprite scheduler (issues start per sprite) and the framebuffer write port.

Parameters:
- CORDW, 10, screen coordinate width; placement inputs are CORDW+1 bits signed.
- SPR_WIDTH, 32, sprite width in pixels; power of two.
- SPR_HEIGHT, 32, sprite height in pixels; power of two.
- SPR_DATAW, 4, colour index width.
- SCALEW, 3, scale factor width; effective scale = value+1, range 1..8.
- SCREEN_W, 800, framebuffer line pitch and clip width.
- SCREEN_H, 480, clip height.
- FB_ADDRW, 19, framebuffer address width.
- TRANSP, all ones of SPR_DATAW, transparent colour key.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clock edge).
- start  in  1  begin a blit; sampled only in IDLE.
- sx, sy  in  CORDW+1 signed  top-left screen position; may be negative or beyond the screen.
- scale_x, scale_y  in  SCALEW  per-axis scale minus one.
- flip_h, flip_v  in  1  mirror the sprite horizontally / vertically.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the blit completes.
- spr_addr  out  $clog2(SPR_WIDTH*SPR_HEIGHT)  sprite ROM read address.
- spr_data  in  SPR_DATAW  ROM data, valid 1 cycle after spr_addr.
- fb_addr  out  FB_ADDRW  framebuffer write address.
- fb_pix  out  SPR_DATAW  framebuffer write data.
- fb_we  out  1  framebuffer write enable.
- fb_ready  in  1  framebuffer accepts the write; 0 stalls the block.

Behaviour:
- Reset (rst=0): state IDLE; busy=0, done=0, fb_we=0, fb_addr=0, fb_pix=0, spr_addr=0; all counters cleared.
- Reset applies mid-blit too: the in-flight pixel is dropped and no done pulse is produced.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start=1. sx, sy, scale_*, flip_* are latched on that edge; input changes afterwards are ignored.
  - RUN walks output pixels row-major: wx 0..SPR_WIDTH*(scale_x+1)-1, then wy 0..SPR_HEIGHT*(scale_y+1)-1.
  - Source column rx advances every scale_x+1 output pixels; source row ry advances every scale_y+1 output rows.
  - Column and row counters reset at each row and at each wrap respectively.
  - spr_addr = cx + cy*SPR_WIDTH, where cx = flip_h ? SPR_WIDTH-1-rx : rx and cy = flip_v ? SPR_HEIGHT-1-ry : ry.
  - After the last pixel's address is issued: RUN -> FLUSH, which drains 2 pipeline stages.
  - FLUSH -> DONE: done=1 for exactly one cycle, busy=0. DONE -> IDLE next cycle.
  - start asserted while busy is ignored. start in the DONE cycle is ignored.
- Pipeline:
  - Stage 0 issues spr_addr and computes screen coordinates X=sx+wx and Y=sy+wy, in CORDW+2 signed.
  - Stage 1 captures spr_data.
  - The output register drives fb_*.
  - Latency: address issue -> fb_we is 2 cycles.
- Write qualification: fb_we=1 only if spr_data!=TRANSP and 0<=X<SCREEN_W and 0<=Y<SCREEN_H.
  - Clipped and transparent pixels still consume their cycle but produce no write.
- fb_addr = X + Y*SCREEN_W, truncated to FB_ADDRW.
- Throughput: 1 output pixel per cycle when fb_ready=1.
  - Unstalled blit time = SPR_WIDTH*(scale_x+1)*SPR_HEIGHT*(scale_y+1) + 2 cycles from accept to done.
- Backpressure: when fb_we=1 and fb_ready=0, every stage holds.
  - spr_addr is held constant, so the ROM re-presents the same data.
  - fb_addr, fb_pix and fb_we stay stable until fb_ready=1.
  - fb_ready is ignored when fb_we=0.
- Fully off-screen sprite: runs the full scan with no writes, then done.

Optional Feature:
- Macro SPRITE_BLIT_HALF_FB_EN.
- Defined: half-resolution packed framebuffer. fb_addr = (X + Y*SCREEN_W) >> 1, and the clipping rules are unchanged.
- Undefined: fb_addr is the full linear address as above.

Test Plan:
- Identity blit: 32x32 ROM, pixel(c,r)=(c+r)%15, sx=0, sy=0, scale 0/0, no flip, fb_ready=1.
  - Expect 1024 writes at addr r*800+c with data (c+r)%15.
  - done exactly 1026 cycles after start is accepted, busy high throughout.
- Transparency + scale: ROM all 4'hF except pixel(0,0)=3, scale_x=1, scale_y=2.
  - Expect exactly 6 writes: addrs 0, 1, 800, 801, 1600, 1601, all data 3.
  - Total 6144 pixel cycles.
- Flip: ROM pixel(c,r)=c[3:0], flip_h=1, sx=sy=10.
  - Write at addr 10*800+10 carries data 31[3:0]=15 → treated as transparent, no write.
  - Write at addr 10*800+11 carries data 30[3:0]=14.
- Clipping: sx=-16, sy=470, scale 0.
  - Writes only for X 0..15, Y 470..479: 160 writes, none with X<0 or Y>479.
  - done still asserted after the full 1026 cycles.
- Backpressure: drop fb_ready for 5 cycles while fb_we=1 on pixel 100.
  - fb_addr and fb_pix stay constant, no pixel lost or duplicated, done delayed by exactly 5 cycles.
- Reset mid-blit: rst=0 at pixel 500.
  - Next cycle busy=0, fb_we=0, no done pulse.
  - A subsequent start performs a full, correct blit.
